interp_sched: RTL

- Round-robin scheduler that shares one trilinear interpolation engine among NUM_REQ hash-encoding lookup lanes.
- Accepts one request bundle at a time: 8 corner features plus 9 x/y/z coordinates, with index 8 as the target point.
- Holds the bundle stable on the engine inputs, pulses the engine's enable, waits for its one-cycle done pulse, and returns the tagged result over a valid/ready response port.
- A timeout guards against a hung engine.

---
 rtl/interp_sched.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/interp_sched.sv
`timescale 1ns/1ps
// interp_sched: round-robin front end that shares one trilinear interpolation
// engine among NUM_REQ hash-encoding lookup lanes.
//
// One bundle (8 corner features + 9 x/y/z coordinates, word 8 = target point)
// is accepted at a time. It is latched onto the eng_* outputs, the engine is
// started with a one-cycle eng_en pulse, and its eng_done/eng_result are
// turned into a tagged valid/ready response. If the engine has not answered
// within TIMEOUT_CYC cycles, an error response (rsp_err=1, rsp_data=0) is
// returned instead and err_cnt is bumped.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   req_valid/req_ready  per-lane request handshake (req_ready one-hot or 0)
//   req_feat             NUM_REQ x 8 feature words, lane i at slice i
//   req_x/req_y/req_z    NUM_REQ x 9 coordinate words, lane i at slice i
//   eng_en               engine start pulse
//   eng_feat/eng_x/y/z   latched operands, constant while the engine runs
//   eng_result/eng_done  engine answer and its one-cycle qualifier
//   rsp_valid/rsp_ready  response handshake
//   rsp_id/data/err      requesting lane, interpolated value, timeout flag
//   busy                 high whenever the scheduler is not idle
//   err_cnt              saturating count of timeouts
module interp_sched #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_SIZE   = 32,
  parameter int ID_W        = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*8*DATA_SIZE-1:0] req_feat,
  input  logic [NUM_REQ*9*DATA_SIZE-1:0] req_x,
  input  logic [NUM_REQ*9*DATA_SIZE-1:0] req_y,
  input  logic [NUM_REQ*9*DATA_SIZE-1:0] req_z,
  output logic                           eng_en,
  output logic [8*DATA_SIZE-1:0]         eng_feat,
  output logic [9*DATA_SIZE-1:0]         eng_x,
  output logic [9*DATA_SIZE-1:0]         eng_y,
  output logic [9*DATA_SIZE-1:0]         eng_z,
  input  logic [DATA_SIZE-1:0]           eng_result,
  input  logic                           eng_done,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic [DATA_SIZE-1:0]           rsp_data,
  output logic                           rsp_err,
  output logic                           busy,
  output logic [7:0]                     err_cnt
);

  localparam int FW    = 8 * DATA_SIZE;
  localparam int CW    = 9 * DATA_SIZE;
  localparam int TMR_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state_reg;
  logic [ID_W-1:0]       rr_ptr_reg;
  logic [ID_W-1:0]       tag_reg;
  logic [TMR_W-1:0]      timer_reg;
  logic                  eng_en_reg;
  logic [FW-1:0]         eng_feat_reg;
  logic [CW-1:0]         eng_x_reg;
  logic [CW-1:0]         eng_y_reg;
  logic [CW-1:0]         eng_z_reg;
  logic                  rsp_valid_reg;
  logic [DATA_SIZE-1:0]  rsp_data_reg;
  logic                  rsp_err_reg;
  logic [7:0]            err_cnt_reg;

  logic                  grant_found;
  logic [ID_W-1:0]       grant_idx;
  logic [ID_W-1:0]       cand;
  logic [ID_W-1:0]       rr_ptr_next;

  logic [FW-1:0] lane_feat [NUM_REQ];
  logic [CW-1:0] lane_x    [NUM_REQ];
  logic [CW-1:0] lane_y    [NUM_REQ];
  logic [CW-1:0] lane_z    [NUM_REQ];

  // Per-lane operand views and grant decode. req_ready is also gated by rstn
  // so no handshake can complete while the FSM is held in reset.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign lane_feat[gi] = req_feat[gi*FW +: FW];
      assign lane_x[gi]    = req_x[gi*CW +: CW];
      assign lane_y[gi]    = req_y[gi*CW +: CW];
      assign lane_z[gi]    = req_z[gi*CW +: CW];
      assign req_ready[gi] = rstn && (state_reg == IDLE) && grant_found &&
                             (grant_idx == ID_W'(gi));
    end
  endgenerate

  // Round-robin search starting at rr_ptr: first valid lane wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Pointer moves past the lane just served, so a lane that keeps requesting
  // cannot starve the others.
  assign rr_ptr_next = ID_W'((int'(tag_reg) + 1) % NUM_REQ);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      tag_reg       <= '0;
      timer_reg     <= '0;
      eng_en_reg    <= 1'b0;
      eng_feat_reg  <= '0;
      eng_x_reg     <= '0;
      eng_y_reg     <= '0;
      eng_z_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
      err_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            tag_reg      <= grant_idx;
            eng_feat_reg <= lane_feat[grant_idx];
            eng_x_reg    <= lane_x[grant_idx];
            eng_y_reg    <= lane_y[grant_idx];
            eng_z_reg    <= lane_z[grant_idx];
            eng_en_reg   <= 1'b1;
            state_reg    <= ISSUE;
          end
        end
        ISSUE: begin
          eng_en_reg <= 1'b0;
          timer_reg  <= TMR_W'(TIMEOUT_CYC - 1);
          state_reg  <= WAIT;
        end
        WAIT: begin
          // done is tested first so a completion on the last timer cycle
          // is still reported as a good result.
          if (eng_done) begin
            rsp_data_reg  <= eng_result;
            rsp_err_reg   <= 1'b0;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end else if (timer_reg == '0) begin
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b1;
            rsp_valid_reg <= 1'b1;
            if (err_cnt_reg != 8'hFF) begin
              err_cnt_reg <= err_cnt_reg + 8'd1;
            end
            state_reg     <= RESP;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rr_ptr_reg    <= rr_ptr_next;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign eng_en    = eng_en_reg;
  assign eng_feat  = eng_feat_reg;
  assign eng_x     = eng_x_reg;
  assign eng_y     = eng_y_reg;
  assign eng_z     = eng_z_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = tag_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;
  assign busy      = (state_reg != IDLE);
  assign err_cnt   = err_cnt_reg;

endmodule
